// File: rtl/cmp_pkg.sv
// cmp_pkg: shared state encoding and digit-count helper for the sequential comparator
package cmp_pkg;
   typedef enum logic [1:0] {CMP_IDLE, CMP_RUN, CMP_DONE} cmp_state_e;
   localparam int CMP_DIGIT = 8;
   function automatic int cmp_ndig(input int width, input int digit);
      return width / digit;
   endfunction
endpackage

// File: rtl/cmp_digit.sv
// cmp_digit: combinational magnitude compare of two DIGIT-bit slices, optional signed top digit
module cmp_digit import cmp_pkg::*; #(
   parameter int DIGIT = CMP_DIGIT
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             invert_msb,
   output logic             gt,
   output logic             lt
);
   logic [DIGIT-1:0] w_m, w_a, w_b;
   // flipping the sign bit maps two's-complement order onto unsigned order
   assign w_m = DIGIT'(invert_msb) << (DIGIT - 1);
   assign w_a = a ^ w_m;
   assign w_b = b ^ w_m;
   assign gt  = w_a > w_b;
   assign lt  = w_a < w_b;
endmodule

// File: rtl/cmp_seq.sv
// cmp_seq: multi-cycle MSB-first digit-serial magnitude comparator with valid/ready handshakes
module cmp_seq import cmp_pkg::*; #(
   parameter  int WIDTH      = 32,
   parameter  int DIGIT      = CMP_DIGIT,
   parameter  int EARLY_EXIT = 1,
   localparam int NDIG       = cmp_ndig(WIDTH, DIGIT),
   localparam int CW         = $clog2(NDIG + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             is_signed,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             greater,
   output logic             less,
   output logic             equal,
   output logic [CW-1:0]    cycles
);
   if (WIDTH % DIGIT != 0) begin : g_chk
      $error("cmp_seq: WIDTH must be a multiple of DIGIT");
   end
   cmp_state_e       r_state;
   logic [WIDTH-1:0] r_a, r_b;
   logic             r_sgn, r_sgt, r_slt, r_gt, r_lt, r_eq;
   logic [CW-1:0]    r_idx, r_cyc;
   logic             w_gt, w_lt, w_fgt, w_flt, w_exit;
   cmp_digit #(.DIGIT(DIGIT)) u_digit (
      .a          (r_a[WIDTH-1 -: DIGIT]),
      .b          (r_b[WIDTH-1 -: DIGIT]),
      .invert_msb (r_sgn && r_idx == '0),
      .gt         (w_gt),
      .lt         (w_lt)
   );
   // the first differing digit decides; later digits only matter for constant-latency mode
   assign w_fgt  = (r_sgt || r_slt) ? r_sgt : w_gt;
   assign w_flt  = (r_sgt || r_slt) ? r_slt : w_lt;
   assign w_exit = r_idx == CW'(NDIG - 1) || (EARLY_EXIT != 0 && (w_gt || w_lt));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state <= CMP_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_sgn   <= 1'b0;
         r_sgt   <= 1'b0;
         r_slt   <= 1'b0;
         r_gt    <= 1'b0;
         r_lt    <= 1'b0;
         r_eq    <= 1'b0;
         r_idx   <= '0;
         r_cyc   <= '0;
      end else
         case (r_state)
            CMP_IDLE:
               if (start_valid) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_sgn   <= is_signed;
                  r_idx   <= '0;
                  r_sgt   <= 1'b0;
                  r_slt   <= 1'b0;
                  r_state <= CMP_RUN;
               end
            CMP_RUN: begin
               r_sgt <= w_fgt;
               r_slt <= w_flt;
               if (w_exit) begin
                  r_gt    <= w_fgt;
                  r_lt    <= w_flt;
                  r_eq    <= !(w_fgt || w_flt);
                  r_cyc   <= r_idx + CW'(1);
                  r_state <= CMP_DONE;
               end else begin
                  r_idx <= r_idx + CW'(1);
                  r_a   <= r_a << DIGIT;
                  r_b   <= r_b << DIGIT;
               end
            end
            CMP_DONE:
               if (res_ready) begin
                  r_gt    <= 1'b0;
                  r_lt    <= 1'b0;
                  r_eq    <= 1'b0;
                  r_cyc   <= '0;
                  r_state <= CMP_IDLE;
               end
            default: r_state <= CMP_IDLE;
         endcase
   assign start_ready = r_state == CMP_IDLE;
   assign res_valid   = r_state == CMP_DONE;
   assign greater     = r_gt;
   assign less        = r_lt;
   assign equal       = r_eq;
   assign cycles      = r_cyc;
endmodule
